// File: rtl/spm_port_arb_pkg.sv
// spm_port_arb_pkg: shared bus widths, FSM state encodings and round-robin pointer values for the SPM port arbiter.
package spm_port_arb_pkg;
  localparam int SPM_ADDR_W = 12;
  localparam int WORD_DATA_W = 32;
  typedef logic [SPM_ADDR_W-1:0] spm_addr_t;
  typedef logic [WORD_DATA_W-1:0] word_t;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
  typedef enum logic {PTR_M0 = 1'b0, PTR_M1 = 1'b1} ptr_t;
endpackage

// File: rtl/spm_port_arb_if.sv
// spm_port_arb_if: two requester handshakes plus the single SPM port they share.
interface spm_port_arb_if;
  import spm_port_arb_pkg::*;
  logic m0_req, m0_we, m0_rdy;
  spm_addr_t m0_addr;
  word_t m0_wr_data, m0_rd_data;
  logic m1_req, m1_we, m1_rdy;
  spm_addr_t m1_addr;
  word_t m1_wr_data, m1_rd_data;
  spm_addr_t spm_addr;
  word_t spm_din, spm_dout;
  logic spm_we;
  logic [1:0] owner;
  modport slave (
    input m0_req, m0_we, m0_addr, m0_wr_data, m1_req, m1_we, m1_addr, m1_wr_data, spm_dout,
    output m0_rdy, m0_rd_data, m1_rdy, m1_rd_data, spm_addr, spm_din, spm_we, owner
  );
  modport master (
    output m0_req, m0_we, m0_addr, m0_wr_data, m1_req, m1_we, m1_addr, m1_wr_data, spm_dout,
    input m0_rdy, m0_rd_data, m1_rdy, m1_rd_data, spm_addr, spm_din, spm_we, owner
  );
endinterface

// File: rtl/spm_port_arb.sv
// spm_port_arb: round-robin arbiter giving two requesters 3-cycle accesses to one SPM port.
module spm_port_arb
  import spm_port_arb_pkg::*;
(
  input logic clk,
  input logic rst_n,
  spm_port_arb_if.slave bus
);
  state_t state, state_nxt;
  ptr_t ptr;
  logic [1:0] grant, owner_q;
  logic any_req, rsp, rdy0, rdy1;
  always_comb begin
    any_req = bus.m0_req | bus.m1_req;
    grant[1] = bus.m1_req & (~bus.m0_req | (ptr == PTR_M1));
    grant[0] = bus.m0_req & ~grant[1];
    state_nxt = state == IDLE ? (any_req ? ACCESS : IDLE) : state == ACCESS ? RESP : IDLE;
    rsp = state == RESP;
    rdy0 = rsp & owner_q[0];
    rdy1 = rsp & owner_q[1];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // Requests are only looked at in IDLE; the winner's port is frozen for ACCESS/RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= PTR_M0;
      owner_q <= 2'b00;
      bus.spm_we <= 1'b0;
      bus.spm_addr <= '0;
      bus.spm_din <= '0;
    end else if (state == IDLE && any_req) begin
      ptr <= grant[0] ? PTR_M1 : PTR_M0;
      owner_q <= grant;
      bus.spm_we <= grant[1] ? bus.m1_we : bus.m0_we;
      bus.spm_addr <= grant[1] ? bus.m1_addr : bus.m0_addr;
      bus.spm_din <= grant[1] ? bus.m1_wr_data : bus.m0_wr_data;
    end else if (state == ACCESS) begin
      bus.spm_we <= 1'b0;
    end else if (state == RESP) begin
      owner_q <= 2'b00;
    end
  end
  assign bus.owner = owner_q;
  assign bus.m0_rdy = rdy0;
  assign bus.m1_rdy = rdy1;
  assign bus.m0_rd_data = rdy0 ? bus.spm_dout : '0;
  assign bus.m1_rd_data = rdy1 ? bus.spm_dout : '0;
endmodule

// File: doc/spm_port_arb.md
SPM_PORT_ARB -- requirements
Module: spm_port_arb

Interface
REQ-001 Parameters: none; widths SHALL come from the shared SpmAddrBus (12 b) and WordDataBus (32 b) definitions.
REQ-002 clk  in  1  system clock; all state SHALL update on posedge clk.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 m0_req  in  1  requester 0 access request (level, held until m0_rdy).
REQ-005 m0_we  in  1  requester 0 write enable (1 = write, 0 = read).
REQ-006 m0_addr  in  12  requester 0 word address.
REQ-007 m0_wr_data  in  32  requester 0 write data.
REQ-008 m0_rdy  out  1  requester 0 access complete, one-cycle pulse.
REQ-009 m0_rd_data  out  32  requester 0 read data, valid while m0_rdy=1.
REQ-010 m1_req, m1_we, m1_addr, m1_wr_data, m1_rdy, m1_rd_data SHALL mirror REQ-004..009 for requester 1.
REQ-011 spm_addr  out  12, spm_din  out  32, spm_we  out  1: drive one SPM port; spm_dout  in  32  that port's read data (1-cycle synchronous read).
REQ-012 owner  out  2  one-hot current grant {m1,m0}; 2'b00 when idle.

Function
REQ-013 FSM states SHALL be IDLE, ACCESS, RESP; one access SHALL occupy exactly 3 cycles; throughput one access per 3 cycles.
REQ-014 IDLE: if any req is sampled high, the winner SHALL be chosen, its addr/wr_data/we registered onto spm_addr/spm_din/spm_we and owner, and the state SHALL go to ACCESS; otherwise it SHALL stay IDLE with spm_we=0.
REQ-015 ACCESS: the SPM samples the registered port; next state SHALL be RESP; spm_we SHALL clear at the ACCESS->RESP edge, so it is high for exactly one cycle.
REQ-016 RESP: owner's rdy SHALL be 1 combinationally and its rd_data SHALL equal spm_dout; next state SHALL be IDLE; owner SHALL clear.
REQ-017 Non-owner rdy SHALL be 0 and rd_data SHALL be 32'h0 at all times; owner rd_data SHALL be 32'h0 outside RESP.
REQ-018 Writes SHALL also pulse rdy in RESP; rd_data on a write SHALL equal spm_dout (don't-care to requester).
REQ-019 Arbitration SHALL be round-robin: a 1-bit priority pointer SHALL favour the requester not granted last; pointer SHALL toggle only on a grant.
REQ-020 A single requesting master SHALL be granted regardless of pointer.
REQ-021 Requests SHALL be sampled only in IDLE; req changes during ACCESS/RESP SHALL be ignored.
REQ-022 A req dropped mid-access (protocol violation) SHALL NOT abort: the access SHALL complete and rdy SHALL still pulse.
REQ-023 A requester holding req after rdy SHALL be treated as a new request at the next IDLE sample.
REQ-024 Latency: req sampled at edge E0 -> rdy high in the cycle after E1.
REQ-025 spm_addr and spm_din SHALL hold their last values when idle; only spm_we and owner SHALL be forced to 0.

Reset
REQ-026 On reset low, asynchronously: state=IDLE, pointer favours m0, owner=2'b00, spm_we=0, spm_addr=12'h0, spm_din=32'h0, all rdy=0, all rd_data=32'h0.
REQ-027 Reset during ACCESS or RESP SHALL abandon the access with no rdy pulse; a write whose ACCESS edge has already occurred SHALL stay in SPM.
REQ-028 After reset release the first grant SHALL go to m0 if both request.

Structure
REQ-029 State encodings (2 b) and pointer values SHALL live in a shared header spm_arb.h beside spm.h; bus widths SHALL reuse the existing SPM and word-bus definitions.
REQ-030 No sub-module; the round-robin pick SHALL be inline combinational logic; spm_port_arb SHALL instantiate in the top level next to the SPM dual-port RAM.

Verification
REQ-031 Write then read: m0 writes addr 12'h010 data 32'hDEAD_BEEF, then reads 12'h010 -> m0_rdy pulses twice, second with m0_rd_data=32'hDEAD_BEEF; spm_we high exactly one cycle.
REQ-032 Contention: m0 and m1 both reading continuously from reset -> grants m0,m1,m0,m1; each rdy one cycle, 3 cycles apart.
REQ-033 Single requester: m1 alone issues 4 reads of 12'h000..003 preloaded 32'h1..4 -> 4 m1_rdy pulses with data 1..4; m0_rdy stays 0.
REQ-034 Mid-access drop: m0 read 12'h020, drop req in ACCESS -> m0_rdy still pulses in RESP, then IDLE with owner=0.
REQ-035 Reset in ACCESS: assert reset during m1 write of 32'hCAFE_0001 -> no m1_rdy, all outputs at reset values, next grant to m0 when both request.
REQ-036 Idle hold: no requests for 10 cycles -> spm_we=0, owner=2'b00, all rdy=0 throughout.
